// File: rtl/sal_sched_pkg.sv
// Shared command encoding, timer width and default DDR spacing for the SAL scheduler.
// Latency: none, this package holds only types, constants and one helper.
// Backpressure: not applicable.
package sal_sched_pkg;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_REF,
    CMD_ACT,
    CMD_RD,
    CMD_WR,
    CMD_PRE
  } cmd_e;

  // Wide enough for any spacing up to 16 cycles (counters hold T-1).
  localparam int TIMER_W   = 4;

  localparam int DEF_T_CCD = 4;
  localparam int DEF_T_RRD = 4;
  localparam int DEF_T_WTR = 6;
  localparam int DEF_T_RTW = 8;

  // Count down towards zero and stay there.
  function automatic logic [TIMER_W-1:0] sat_dec(input logic [TIMER_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

endpackage

// File: rtl/sal_rr_picker.sv
// Rotating-priority pick: first set request at or after i_ptr, wrapping at N.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides whether the pick is used.
module sal_rr_picker #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_vld
);

  logic [IW-1:0] w_pos;

  // Scan from the pointer; the IW-bit sum wraps because N is a power of two.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    w_pos = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = i_ptr + IW'(k);
      if (!o_vld && i_req[w_pos]) begin
        o_vld        = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_idx        = w_pos;
      end
    end
  end

endmodule

// File: rtl/sal_cmd_arbiter.sv
// Per-cycle DRAM command pick (REF > RD/WR > PRE > ACT) across banks, enforcing tCCD/tRRD and, when SAL_TURNAROUND_EN is defined, tWTR/tRTW.
// Latency: grants are combinational from requests and registered timers (zero cycles).
// Backpressure: requesters hold their request until granted; timer-blocked classes simply wait.
module sal_cmd_arbiter
  import sal_sched_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int RA_W      = 16,
  parameter int CA_W      = 11,
  parameter int T_CCD     = DEF_T_CCD,
  parameter int T_RRD     = DEF_T_RRD,
  parameter int T_WTR     = DEF_T_WTR,
  parameter int T_RTW     = DEF_T_RTW
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ref_req,
  input  logic [NUM_BANKS-1:0]         bank_idle,
  input  logic [NUM_BANKS-1:0]         act_req,
  input  logic [NUM_BANKS-1:0]         rd_req,
  input  logic [NUM_BANKS-1:0]         wr_req,
  input  logic [NUM_BANKS-1:0]         pre_req,
  input  logic [NUM_BANKS*RA_W-1:0]    ra_i,
  input  logic [NUM_BANKS*CA_W-1:0]    ca_i,
  output logic                         ref_gnt,
  output logic                         act_gnt,
  output logic                         rd_gnt,
  output logic                         wr_gnt,
  output logic                         pre_gnt,
  output logic [NUM_BANKS-1:0]         bank_gnt,
  output logic [$clog2(NUM_BANKS)-1:0] ba,
  output logic [RA_W-1:0]              ra,
  output logic [CA_W-1:0]              ca
);

  localparam int BA_W = $clog2(NUM_BANKS);
  localparam logic [TIMER_W-1:0] CCD_LD = TIMER_W'(T_CCD - 1);
  localparam logic [TIMER_W-1:0] RRD_LD = TIMER_W'(T_RRD - 1);

  logic [BA_W-1:0]      r_rr_ptr;
  logic [TIMER_W-1:0]   r_ccd_cnt;
  logic [TIMER_W-1:0]   r_rrd_cnt;

  logic [NUM_BANKS-1:0] w_legal;
  logic [NUM_BANKS-1:0] w_act_v;
  logic [NUM_BANKS-1:0] w_rd_v;
  logic [NUM_BANKS-1:0] w_wr_v;
  logic [NUM_BANKS-1:0] w_pre_v;
  logic                 w_rd_ok;
  logic                 w_wr_ok;
  logic                 w_act_ok;
  logic                 w_ref_ok;
  logic [NUM_BANKS-1:0] w_cas_req;
  logic [NUM_BANKS-1:0] w_act_req;
  logic [NUM_BANKS-1:0] w_cas_gnt;
  logic [NUM_BANKS-1:0] w_pre_gnt;
  logic [NUM_BANKS-1:0] w_act_gnt;
  logic [BA_W-1:0]      w_cas_idx;
  logic [BA_W-1:0]      w_pre_idx;
  logic [BA_W-1:0]      w_act_idx;
  logic                 w_cas_vld;
  logic                 w_pre_vld;
  logic                 w_act_vld;
  cmd_e                 w_cmd;
  logic [NUM_BANKS-1:0] w_bank_gnt;
  logic [BA_W-1:0]      w_idx;
  logic                 w_bank_vld;

  // A bank presenting more than one command is dropped for this cycle.
  always_comb begin
    w_legal = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_legal[b] = ($countones({act_req[b], rd_req[b], wr_req[b], pre_req[b]}) <= 1);
    end
  end

  assign w_act_v = act_req & w_legal;
  assign w_rd_v  = rd_req  & w_legal;
  assign w_wr_v  = wr_req  & w_legal;
  assign w_pre_v = pre_req & w_legal;

`ifdef SAL_TURNAROUND_EN
  localparam logic [TIMER_W-1:0] WTR_LD = TIMER_W'(T_WTR - 1);
  localparam logic [TIMER_W-1:0] RTW_LD = TIMER_W'(T_RTW - 1);

  logic [TIMER_W-1:0] r_wtr_cnt;
  logic [TIMER_W-1:0] r_rtw_cnt;

  assign w_rd_ok = (r_ccd_cnt == '0) && (r_wtr_cnt == '0);
  assign w_wr_ok = (r_ccd_cnt == '0) && (r_rtw_cnt == '0);

  // Bus turnaround spacing: a WR holds off RDs, a RD holds off WRs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wtr_cnt <= '0;
      r_rtw_cnt <= '0;
    end else begin
      r_wtr_cnt <= wr_gnt ? WTR_LD : sat_dec(r_wtr_cnt);
      r_rtw_cnt <= rd_gnt ? RTW_LD : sat_dec(r_rtw_cnt);
    end
  end
`else
  // Turnaround timings have no effect in this build.
  logic w_unused_turnaround;
  assign w_unused_turnaround = ^{T_WTR[0], T_RTW[0]};

  assign w_rd_ok = (r_ccd_cnt == '0);
  assign w_wr_ok = (r_ccd_cnt == '0);
`endif

  // ACT is held off while a refresh is waiting so banks can drain to idle.
  assign w_act_ok  = (r_rrd_cnt == '0) && !ref_req;
  assign w_ref_ok  = ref_req && (&bank_idle) && !(|w_rd_v) && !(|w_wr_v) && !(|w_pre_v);
  assign w_cas_req = (w_rd_v & {NUM_BANKS{w_rd_ok}}) | (w_wr_v & {NUM_BANKS{w_wr_ok}});
  assign w_act_req = w_act_v & {NUM_BANKS{w_act_ok}};

  sal_rr_picker #(.N(NUM_BANKS), .IW(BA_W)) u_cas_pick (
    .i_req (w_cas_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_cas_gnt),
    .o_idx (w_cas_idx),
    .o_vld (w_cas_vld)
  );

  sal_rr_picker #(.N(NUM_BANKS), .IW(BA_W)) u_pre_pick (
    .i_req (w_pre_v),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pre_gnt),
    .o_idx (w_pre_idx),
    .o_vld (w_pre_vld)
  );

  sal_rr_picker #(.N(NUM_BANKS), .IW(BA_W)) u_act_pick (
    .i_req (w_act_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_act_gnt),
    .o_idx (w_act_idx),
    .o_vld (w_act_vld)
  );

  // Class priority; nothing is granted while reset is asserted.
  always_comb begin
    w_cmd = CMD_NOP;
    if (!rst_n)         w_cmd = CMD_NOP;
    else if (w_ref_ok)  w_cmd = CMD_REF;
    else if (w_cas_vld) w_cmd = w_rd_v[w_cas_idx] ? CMD_RD : CMD_WR;
    else if (w_pre_vld) w_cmd = CMD_PRE;
    else if (w_act_vld) w_cmd = CMD_ACT;
  end

  // Route the winning class's bank; REF and idle leave the bank fields at zero.
  always_comb begin
    w_bank_gnt = '0;
    w_idx      = '0;
    case (w_cmd)
      CMD_RD, CMD_WR: begin
        w_bank_gnt = w_cas_gnt;
        w_idx      = w_cas_idx;
      end
      CMD_PRE: begin
        w_bank_gnt = w_pre_gnt;
        w_idx      = w_pre_idx;
      end
      CMD_ACT: begin
        w_bank_gnt = w_act_gnt;
        w_idx      = w_act_idx;
      end
      default: ;
    endcase
  end

  assign w_bank_vld = |w_bank_gnt;
  assign ref_gnt    = (w_cmd == CMD_REF);
  assign act_gnt    = (w_cmd == CMD_ACT);
  assign rd_gnt     = (w_cmd == CMD_RD);
  assign wr_gnt     = (w_cmd == CMD_WR);
  assign pre_gnt    = (w_cmd == CMD_PRE);
  assign bank_gnt   = w_bank_gnt;
  assign ba         = w_idx;
  assign ra         = w_bank_vld ? ra_i[w_idx*RA_W +: RA_W] : '0;
  assign ca         = w_bank_vld ? ca_i[w_idx*CA_W +: CA_W] : '0;

  // Shared pointer moves past each bank winner; CAS/ACT spacing counters reload on grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr  <= '0;
      r_ccd_cnt <= '0;
      r_rrd_cnt <= '0;
    end else begin
      if (w_bank_vld) r_rr_ptr <= w_idx + BA_W'(1);
      r_ccd_cnt <= (rd_gnt || wr_gnt) ? CCD_LD : sat_dec(r_ccd_cnt);
      r_rrd_cnt <= act_gnt ? RRD_LD : sat_dec(r_rrd_cnt);
    end
  end

`ifndef SYNTHESIS
  // Each bank must present at most one command at a time.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (&w_legal) else $error("sal_cmd_arbiter: bank with multiple commands, legal=%b", w_legal);
    end
  end
`endif

endmodule

// File: tb/tb_sal_cmd_arbiter.sv
// Directed scenarios then random traffic against a time-stamp reference model of the scheduler.
// Latency: grants are checked in the same cycle the requests are presented.
// Backpressure: requests are held by the bench until the model says they were granted.
module tb_sal_cmd_arbiter;

  localparam int NB    = 8;
  localparam int RA_W  = 16;
  localparam int CA_W  = 11;
  localparam int T_CCD = 4;
  localparam int T_RRD = 4;
  localparam int T_WTR = 6;
  localparam int T_RTW = 8;
`ifdef SAL_TURNAROUND_EN
  localparam int WR_RD_GAP = T_WTR;
`else
  localparam int WR_RD_GAP = T_CCD;
`endif

  typedef struct packed {
    logic            r;
    logic            a;
    logic            rd;
    logic            wr;
    logic            p;
    logic [NB-1:0]   bg;
    logic [2:0]      ba;
    logic [RA_W-1:0] ra;
    logic [CA_W-1:0] ca;
  } out_t;

  logic               clk;
  logic               rst_n;
  logic               ref_req;
  logic [NB-1:0]      bank_idle, act_req, rd_req, wr_req, pre_req;
  logic [NB*RA_W-1:0] ra_i;
  logic [NB*CA_W-1:0] ca_i;
  logic               ref_gnt, act_gnt, rd_gnt, wr_gnt, pre_gnt;
  logic [NB-1:0]      bank_gnt;
  logic [2:0]         ba;
  logic [RA_W-1:0]    ra;
  logic [CA_W-1:0]    ca;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   t_last = 0;
  out_t last_g;
  int   m_ptr = 0;
  int   m_last_cas = -1000, m_last_rd = -1000, m_last_wr = -1000, m_last_act = -1000;

  sal_cmd_arbiter #(
    .NUM_BANKS(NB), .RA_W(RA_W), .CA_W(CA_W),
    .T_CCD(T_CCD), .T_RRD(T_RRD), .T_WTR(T_WTR), .T_RTW(T_RTW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ref_req(ref_req), .bank_idle(bank_idle),
    .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req),
    .ra_i(ra_i), .ca_i(ca_i),
    .ref_gnt(ref_gnt), .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt),
    .bank_gnt(bank_gnt), .ba(ba), .ra(ra), .ca(ca)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference: grant classes are spaced by comparing the current cycle with the
  // cycle of the last grant of the relevant class.
  function automatic out_t model_out();
    out_t o;
    bit   found;
    bit   rd_ok, wr_ok;
    int   sel, b;
    o = '0;
    found = 0;
    sel = 0;
    if (!rst_n) return o;
    if (ref_req && (&bank_idle) && ((rd_req | wr_req | pre_req) == '0)) begin
      o.r = 1'b1;
      return o;
    end
    rd_ok = (cyc - m_last_cas) >= T_CCD;
    wr_ok = rd_ok;
`ifdef SAL_TURNAROUND_EN
    rd_ok = rd_ok && ((cyc - m_last_wr) >= T_WTR);
    wr_ok = wr_ok && ((cyc - m_last_rd) >= T_RTW);
`endif
    for (int k = 0; k < NB; k++) begin
      b = (m_ptr + k) % NB;
      if (!found && ((rd_req[b] && rd_ok) || (wr_req[b] && wr_ok))) begin
        found = 1; sel = b; o.rd = rd_req[b]; o.wr = !rd_req[b];
      end
    end
    for (int k = 0; k < NB; k++) begin
      b = (m_ptr + k) % NB;
      if (!found && pre_req[b]) begin
        found = 1; sel = b; o.p = 1'b1;
      end
    end
    if (!ref_req && (cyc - m_last_act) >= T_RRD) begin
      for (int k = 0; k < NB; k++) begin
        b = (m_ptr + k) % NB;
        if (!found && act_req[b]) begin
          found = 1; sel = b; o.a = 1'b1;
        end
      end
    end
    if (found) begin
      o.bg = NB'(1) << sel;
      o.ba = 3'(sel);
      o.ra = ra_i[sel*RA_W +: RA_W];
      o.ca = ca_i[sel*CA_W +: CA_W];
    end
    return o;
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o.r = ref_gnt; o.a = act_gnt; o.rd = rd_gnt; o.wr = wr_gnt; o.p = pre_gnt;
    o.bg = bank_gnt; o.ba = ba; o.ra = ra; o.ca = ca;
    return o;
  endfunction

  // Check one cycle (inputs already driven), advance the model, retire granted requests.
  task automatic tick(input string tag);
    out_t e;
    #2;
    e = model_out();
    last_g = dut_out();
    t_last = cyc;
    check(tag, 64'(last_g), 64'(e));
    @(posedge clk);
    if (!rst_n) begin
      m_ptr = 0;
      m_last_cas = -1000; m_last_rd = -1000; m_last_wr = -1000; m_last_act = -1000;
    end else begin
      if (e.a | e.rd | e.wr | e.p) m_ptr = (int'(e.ba) + 1) % NB;
      if (e.rd | e.wr) m_last_cas = cyc;
      if (e.rd) m_last_rd = cyc;
      if (e.wr) m_last_wr = cyc;
      if (e.a) m_last_act = cyc;
    end
    cyc++;
    @(negedge clk);
    if (e.r)  ref_req = 1'b0;
    if (e.a)  act_req[e.ba] = 1'b0;
    if (e.rd) rd_req[e.ba] = 1'b0;
    if (e.wr) wr_req[e.ba] = 1'b0;
    if (e.p)  pre_req[e.ba] = 1'b0;
  endtask

  task automatic rand_addr();
    for (int b = 0; b < NB; b++) begin
      ra_i[b*RA_W +: RA_W] = RA_W'($urandom);
      ca_i[b*CA_W +: CA_W] = CA_W'($urandom);
    end
  endtask

  int g2, g5, gw, gr, n_act;
  int ord[NB];
  int tm[NB];

  initial begin
    rst_n = 1'b0; ref_req = 1'b1; bank_idle = '0;
    act_req = '1; rd_req = '1; wr_req = '1; pre_req = '1;
    rand_addr();
    @(negedge clk);

    // Reset with everything requesting: no grants at all.
    for (int i = 0; i < 3; i++) tick("rst_all_req");
    check("rst_no_grant", 64'(last_g), 64'(0));

    // Release with a bank still open: REF must wait for all banks idle.
    act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0;
    ref_req = 1'b1; bank_idle = 8'h7F; rst_n = 1'b1;
    tick("ref_not_idle");
    check("ref_blocked", 64'(ref_gnt), 64'(0));
    bank_idle = '1;
    tick("ref_idle");
    check("ref_granted", 64'({last_g.r, last_g.bg}), 64'({1'b1, 8'h00}));

    // Two RDs: tCCD spacing, rotating order from pointer 0.
    g2 = -1; g5 = -1;
    rd_req[2] = 1'b1; rd_req[5] = 1'b1;
    for (int i = 0; i < 12 && g5 < 0; i++) begin
      tick("ccd");
      if (last_g.rd && last_g.ba == 3'd2) g2 = t_last;
      if (last_g.rd && last_g.ba == 3'd5) g5 = t_last;
    end
    check("ccd_first_bank2", 64'(g2 >= 0), 64'(1));
    check("ccd_gap", 64'(g5 - g2), 64'(T_CCD));

    // All banks ACT from reset: banks 0..7 in order, tRRD apart.
    rst_n = 1'b0;
    tick("rst_pulse");
    rst_n = 1'b1; act_req = '1; n_act = 0;
    for (int i = 0; i < 60 && n_act < NB; i++) begin
      tick("rrd");
      if (last_g.a) begin ord[n_act] = int'(last_g.ba); tm[n_act] = t_last; n_act++; end
    end
    check("rrd_count", 64'(n_act), 64'(NB));
    for (int i = 0; i < n_act; i++) begin
      check("rrd_order", 64'(ord[i]), 64'(i));
      if (i > 0) check("rrd_gap", 64'(tm[i] - tm[i-1]), 64'(T_RRD));
    end

    // Reset mid-countdown clears tRRD: next ACT goes straight away.
    rst_n = 1'b0; act_req[4] = 1'b1;
    tick("rst_mid");
    rst_n = 1'b1;
    tick("post_rst_act");
    check("rst_clears_rrd", 64'({last_g.a, last_g.bg}), 64'({1'b1, 8'h10}));

    for (int i = 0; i < 4; i++) tick("idle");

    // Refresh pending with an open bank: PRE drains, ACT waits, REF then ACT.
    ref_req = 1'b1; act_req[1] = 1'b1; pre_req[3] = 1'b1; bank_idle = 8'hF7;
    tick("ref_pre");
    check("ref_pre_first", 64'({last_g.p, last_g.a, last_g.r, last_g.bg}), 64'({3'b100, 8'h08}));
    bank_idle[3] = 1'b1;
    tick("ref_after_pre");
    check("ref_after_idle", 64'({last_g.r, last_g.a}), 64'(2'b10));
    tick("act_after_ref");
    check("act_after_ref", 64'({last_g.a, last_g.bg}), 64'({1'b1, 8'h02}));

    // WR then RD on another bank: spacing is tWTR with turnaround, else tCCD.
    gw = -1; gr = -1;
    wr_req[0] = 1'b1;
    for (int i = 0; i < 12 && gw < 0; i++) begin
      tick("wr");
      if (last_g.wr && last_g.ba == 3'd0) gw = t_last;
    end
    rd_req[1] = 1'b1;
    for (int i = 0; i < 20 && gr < 0; i++) begin
      tick("wr_rd");
      if (last_g.rd && last_g.ba == 3'd1) gr = t_last;
    end
    check("wr_granted", 64'(gw >= 0), 64'(1));
    check("wr_rd_gap", 64'(gr - gw), 64'(WR_RD_GAP));

    // CAS outranks ACT in the same cycle; ACT follows next cycle.
    for (int i = 0; i < 10; i++) tick("idle");
    rd_req[4] = 1'b1; act_req[0] = 1'b1;
    tick("cas_vs_act");
    check("cas_first", 64'({last_g.rd, last_g.a, last_g.bg}), 64'({2'b10, 8'h10}));
    tick("act_next");
    check("act_next", 64'({last_g.a, last_g.bg}), 64'({1'b1, 8'h01}));

    // Random legal traffic, with a reset in the middle.
    for (int cy = 0; cy < 2000; cy++) begin
      rst_n = !(cy >= 1000 && cy < 1002);
      for (int b = 0; b < NB; b++) begin
        if (!(act_req[b] | rd_req[b] | wr_req[b] | pre_req[b]) && $urandom_range(0, 15) == 0) begin
          case ($urandom_range(0, 3))
            0:       act_req[b] = 1'b1;
            1:       if (!ref_req) rd_req[b] = 1'b1;
            2:       if (!ref_req) wr_req[b] = 1'b1;
            default: if (!ref_req) pre_req[b] = 1'b1;
          endcase
        end
      end
      if (!ref_req && $urandom_range(0, 31) == 0) ref_req = 1'b1;
      bank_idle = ($urandom_range(0, 1) == 1) ? '1 : NB'($urandom);
      rand_addr();
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
